// File: rtl/des32b_align.sv
// des32b_align: serial-to-parallel deserializer with word alignment.
//
// The block hunts for SYNC_WORD at any bit offset. It then confirms that
// LOCK_CNT consecutive syncs land on the word boundary, and after that it
// delivers one 32-bit word per 32 bit-clocks.
//
// Ports:
//   CLKBit    in   1   bit-rate clock (the only clock)
//   RST       in   1   synchronous, active-high reset
//   DataIn    in   1   serial data, MSB first
//   Realign   in   1   forces a return to HUNT
//   DataOut   out  32  last deserialized word
//   DataValid out  1   one-cycle strobe when DataOut updates
//   CLKWord   out  1   word clock (bit 4 of the word counter)
//   Locked    out  1   high only in LOCKED
//   ErrCnt    out  16  sequence error count (only with DES_SEQCHK_EN)
//
// Build option: define DES_SEQCHK_EN to add the payload sequence checker
// and the ErrCnt port. The checker expects each word to be the previous
// word + 1.
//
// state  | meaning
// HUNT   | searching every cycle for SYNC_WORD at any bit offset
// VERIFY | boundary fixed, counting consecutive boundary-aligned syncs
// LOCKED | aligned, strobing one payload word per boundary

module des32b_align #(
    parameter logic [31:0] SYNC_WORD = 32'hF0F0_A5C3,
    parameter int unsigned LOCK_CNT  = 4
) (
    input  logic        CLKBit,
    input  logic        RST,
    input  logic        DataIn,
    input  logic        Realign,
    output logic [31:0] DataOut,
    output logic        DataValid,
    output logic        CLKWord,
    output logic        Locked
`ifdef DES_SEQCHK_EN
    ,
    output logic [15:0] ErrCnt
`endif
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_CNT_W = 4'(LOCK_CNT);

    state_t      state;
    logic [31:0] sr;
    logic [4:0]  wc;
    logic [3:0]  mc;
    logic        match;
    logic        boundary;

`ifdef DES_SEQCHK_EN
    // The first word after entering LOCKED has no predecessor to compare with.
    logic        first_word;
`endif

    assign match    = (sr == SYNC_WORD);
    assign boundary = (wc == 5'd0);
    assign CLKWord  = wc[4];

    always_ff @(posedge CLKBit) begin
        if (RST) begin
            state     <= HUNT;
            sr        <= '0;
            wc        <= 5'b11111;
            mc        <= '0;
            DataOut   <= '0;
            DataValid <= 1'b0;
            Locked    <= 1'b0;
`ifdef DES_SEQCHK_EN
            ErrCnt     <= '0;
            first_word <= 1'b0;
`endif
        end else begin
            sr        <= {sr[30:0], DataIn};
            wc        <= wc - 5'd1;
            DataValid <= 1'b0;

            if (Realign) begin
                // The word counter keeps free-running; only the FSM restarts.
                state  <= HUNT;
                mc     <= '0;
                Locked <= 1'b0;
            end else begin
                case (state)
                    HUNT: begin
                        if (match) begin
                            // The next word's first bit arrives this edge,
                            // so its last bit lands when wc reaches 0.
                            wc <= 5'd31;
                            mc <= 4'd1;
                            if (LOCK_CNT_W == 4'd1) begin
                                state  <= LOCKED;
                                Locked <= 1'b1;
`ifdef DES_SEQCHK_EN
                                first_word <= 1'b1;
`endif
                            end else begin
                                state <= VERIFY;
                            end
                        end
                    end

                    VERIFY: begin
                        if (boundary) begin
                            if (match) begin
                                mc <= mc + 4'd1;
                                if (mc + 4'd1 == LOCK_CNT_W) begin
                                    state  <= LOCKED;
                                    Locked <= 1'b1;
`ifdef DES_SEQCHK_EN
                                    first_word <= 1'b1;
`endif
                                end
                            end else begin
                                state <= HUNT;
                                mc    <= '0;
                            end
                        end
                    end

                    LOCKED: begin
                        if (boundary) begin
                            DataOut   <= sr;
                            DataValid <= 1'b1;
`ifdef DES_SEQCHK_EN
                            first_word <= 1'b0;
                            if (!first_word && (sr != DataOut + 32'd1) &&
                                (ErrCnt != 16'hFFFF)) begin
                                ErrCnt <= ErrCnt + 16'd1;
                            end
`endif
                        end
                    end

                    default: begin
                        state  <= HUNT;
                        mc     <= '0;
                        Locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/des32b_align.md
DES32B_ALIGN -- requirements
Module: des32b_align

Interface
REQ-001 SHALL have parameter SYNC_WORD, default 32'hF0F0_A5C3, the training word the serializer transmits before payload.
REQ-002 SHALL have parameter LOCK_CNT, default 4 (range 1..15), the number of consecutive aligned SYNC_WORD matches required to lock.
REQ-003 SHALL have port CLKBit  in  1  bit-rate clock; the only clock in the block.
REQ-004 SHALL have port RST  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port DataIn  in  1  serial data, MSB of each word first, one bit per CLKBit rising edge.
REQ-006 SHALL have port Realign  in  1  level/pulse; forces a return to alignment search.
REQ-007 SHALL have port DataOut  out  32  last deserialized word.
REQ-008 SHALL have port DataValid  out  1  one-cycle strobe, high in the cycle DataOut updates.
REQ-009 SHALL have port CLKWord  out  1  word clock, equal to bit 4 of the word counter.
REQ-010 SHALL have port Locked  out  1  high in LOCKED state only.
REQ-011 SHALL have port ErrCnt  out  16  sequence error count (present only per REQ-027).

Function
REQ-012 Shift register SR[31:0] SHALL update every edge: SR <= {SR[30:0], DataIn}.
REQ-013 Word counter WC[4:0] SHALL decrement every edge and wrap 0->31, except when reloaded per REQ-015; the word boundary is the cycle with WC==0.
REQ-014 FSM states SHALL be HUNT, VERIFY and LOCKED, with match counter MC[3:0].
REQ-015 In HUNT, SR==SYNC_WORD in any cycle SHALL load WC<=31, set MC<=1, and go to VERIFY; with LOCK_CNT==1 it SHALL go directly to LOCKED.
REQ-016 In VERIFY at a boundary, SR==SYNC_WORD SHALL increment MC, and go to LOCKED when the incremented MC equals LOCK_CNT; SR!=SYNC_WORD SHALL go to HUNT with MC<=0.
REQ-017 Non-boundary SYNC_WORD matches in VERIFY or LOCKED SHALL be ignored.
REQ-018 In LOCKED at each boundary, DataOut SHALL be loaded with SR and DataValid SHALL be asserted for exactly one cycle on the following edge.
REQ-019 Latency: the last bit of a word is sampled at edge k; DataOut/DataValid SHALL update at edge k+1.
REQ-020 DataValid SHALL never assert outside LOCKED; DataOut SHALL hold its value between strobes and in HUNT/VERIFY.
REQ-021 LOCKED SHALL persist regardless of payload content; it SHALL be left only via Realign or RST.
REQ-022 Realign high SHALL move the FSM to HUNT on the next edge from any state, with MC<=0 and Locked low; WC keeps free-running.
REQ-023 RST SHALL take priority over Realign and over all FSM transitions.
REQ-024 CLKWord SHALL be a 32-cycle-period square wave (16 high/16 low) except at a WC reload, where it goes high immediately.

Reset
REQ-025 On RST high at an edge: SR=0, WC=5'b11111, MC=0, state=HUNT, DataOut=0, DataValid=0, Locked=0, ErrCnt=0.
REQ-026 Reset asserted mid-word or mid-lock SHALL abort that word with no DataValid strobe.

Configuration
REQ-027 Macro DES_SEQCHK_EN defined: in LOCKED, each strobed word other than the first after entering LOCKED SHALL be compared with the previous DataOut+1 (mod 2^32); a mismatch SHALL increment ErrCnt, which saturates at 16'hFFFF; ErrCnt clears only on RST.
REQ-028 Macro DES_SEQCHK_EN undefined: the ErrCnt port and its logic SHALL be absent.

Verification
REQ-029 RST, then 4x SYNC_WORD followed by words 0,1,2 -> Locked rises at the 4th sync boundary; DataValid strobes with DataOut=0,1,2 at 32-cycle spacing.
REQ-030 Sync stream misaligned by 7 bits (7 garbage bits first) -> lock still achieved after 4 syncs; DataOut words are bit-exact.
REQ-031 3x SYNC_WORD then 32'h0 -> FSM returns to HUNT; Locked stays 0; no DataValid strobe.
REQ-032 Realign pulsed while LOCKED -> Locked=0 on the next edge, no further DataValid; relock after 4 fresh syncs.
REQ-033 With DES_SEQCHK_EN: words 5,6,9,10 -> ErrCnt=1; RST during a word -> all outputs at reset values, no strobe.
